half_adder_checker: RTL and testbench

Synthesizable response checker that sits at the output end of the half-adder stimulus path. It samples each applied bit pair together with the observed `sum`/`carry` from a half-adder under test, and compares the result against a golden half-adder. It accumulates vector, error and coverage statistics over a start/stop-bounded run, then reports a single pass/fail verdict. It is the hardware counterpart of the team's stimulus-driving benches, used for on-chip/BIST-style checking of the adder.

---
 rtl/half_adder_pkg.sv | 23 ++
 rtl/half_adder_checker_if.sv | 34 +++
 rtl/half_adder.sv | 13 +
 rtl/half_adder_checker.sv | 143 ++++++++++++++
 tb/tb_half_adder_checker.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and constants for the half-adder checker.
//   state_t  : checker run state (IDLE/RUN/DONE)
//   COV_ALL  : coverage mask with every operand pair seen
//   sample_t : one observed sample {bit1,bit2,sum,carry}
package half_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned COV_W   = 4;
   localparam logic [COV_W-1:0] COV_ALL = 4'b1111;

   typedef struct packed {
      logic bit1;
      logic bit2;
      logic sum;
      logic carry;
   } sample_t;

endpackage

// File: rtl/half_adder_checker_if.sv
// Stimulus/result bundle between a driver and the half-adder checker.
//   master : drives start/stop/valid and the observed sample, reads results
//   slave  : the checker; reads the sample, drives status and statistics
interface half_adder_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             i_start;
   logic             i_stop;
   logic             i_valid;
   logic             i_bit1;
   logic             i_bit2;
   logic             i_sum;
   logic             i_carry;
   logic             o_busy;
   logic             o_done;
   logic             o_pass;
   logic             o_mismatch;
   logic [CNT_W-1:0] o_vec_cnt;
   logic [CNT_W-1:0] o_err_cnt;
   logic [3:0]       o_cov;
   logic [3:0]       o_first_err;

   modport master (
      output i_start, i_stop, i_valid, i_bit1, i_bit2, i_sum, i_carry,
      input  o_busy, o_done, o_pass, o_mismatch,
      input  o_vec_cnt, o_err_cnt, o_cov, o_first_err
   );

   modport slave (
      input  i_start, i_stop, i_valid, i_bit1, i_bit2, i_sum, i_carry,
      output o_busy, o_done, o_pass, o_mismatch,
      output o_vec_cnt, o_err_cnt, o_cov, o_first_err
   );
endinterface

// File: rtl/half_adder.sv
// Combinational half adder; used as the golden reference by the checker.
//   i_a, i_b : operands
//   o_sum    : i_a xor i_b
//   o_carry  : i_a and i_b
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;
endmodule

// File: rtl/half_adder_checker.sv
// Response checker for a half adder under test. Compares each valid
// sample against a golden half adder during a start/stop-bounded run and
// accumulates vector/error/coverage statistics plus a pass verdict.
//   i_clk, i_rst_n : clock, async active-low reset
//   io_chk         : slave side of half_adder_checker_if (sample in, results out)
module half_adder_checker
   import half_adder_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   half_adder_checker_if.slave io_chk
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_mismatch;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [3:0]       r_cov;
   logic [3:0]       r_first_err;

   state_t           w_state_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;
   logic             w_mismatch_nxt;
   logic [CNT_W-1:0] w_vec_nxt;
   logic [CNT_W-1:0] w_err_nxt;
   logic [3:0]       w_cov_nxt;
   logic [3:0]       w_first_nxt;
   logic             w_check;
   logic             w_fail;
   logic             w_exp_sum;
   logic             w_exp_carry;
   sample_t          w_sample;

   // Golden reference for the expected outputs
   half_adder u_golden (
      .i_a     (io_chk.i_bit1),
      .i_b     (io_chk.i_bit2),
      .o_sum   (w_exp_sum),
      .o_carry (w_exp_carry)
   );

   assign w_sample = {io_chk.i_bit1, io_chk.i_bit2, io_chk.i_sum, io_chk.i_carry};

   // Next-state, statistics and verdict
   always_comb begin
      w_state_nxt    = r_state;
      w_pass_nxt     = r_pass;
      w_mismatch_nxt = 1'b0;
      w_vec_nxt      = r_vec_cnt;
      w_err_nxt      = r_err_cnt;
      w_cov_nxt      = r_cov;
      w_first_nxt    = r_first_err;
      w_check        = 1'b0;
      w_fail         = (io_chk.i_sum != w_exp_sum) || (io_chk.i_carry != w_exp_carry);

      case (r_state)
         ST_IDLE: begin
            if (io_chk.i_start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // start outranks both stop and a coincident sample
            if (io_chk.i_start) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_check = io_chk.i_valid;
               if (io_chk.i_stop) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (io_chk.i_start) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (io_chk.i_start) begin
         w_pass_nxt  = 1'b0;
         w_vec_nxt   = '0;
         w_err_nxt   = '0;
         w_cov_nxt   = '0;
         w_first_nxt = '0;
      end else if (w_check) begin
         w_vec_nxt = (r_vec_cnt == CNT_MAX) ? r_vec_cnt : r_vec_cnt + CNT_W'(1);
         w_cov_nxt[{io_chk.i_bit1, io_chk.i_bit2}] = 1'b1;
         if (w_fail) begin
            w_mismatch_nxt = 1'b1;
            w_err_nxt = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(1);
            if (r_err_cnt == '0) w_first_nxt = w_sample;
         end
      end

      // Verdict uses the post-sample statistics so a sample coincident with stop counts
      if ((r_state == ST_RUN) && (w_state_nxt == ST_DONE)) begin
         w_pass_nxt = (w_err_nxt == '0) && (w_cov_nxt == COV_ALL);
      end

      w_busy_nxt = (w_state_nxt == ST_RUN);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_mismatch  <= 1'b0;
         r_vec_cnt   <= '0;
         r_err_cnt   <= '0;
         r_cov       <= '0;
         r_first_err <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
         r_mismatch  <= w_mismatch_nxt;
         r_vec_cnt   <= w_vec_nxt;
         r_err_cnt   <= w_err_nxt;
         r_cov       <= w_cov_nxt;
         r_first_err <= w_first_nxt;
      end
   end

   assign io_chk.o_busy      = r_busy;
   assign io_chk.o_done      = r_done;
   assign io_chk.o_pass      = r_pass;
   assign io_chk.o_mismatch  = r_mismatch;
   assign io_chk.o_vec_cnt   = r_vec_cnt;
   assign io_chk.o_err_cnt   = r_err_cnt;
   assign io_chk.o_cov       = r_cov;
   assign io_chk.o_first_err = r_first_err;

endmodule

// File: tb/tb_half_adder_checker.sv
// Self-checking bench for half_adder_checker: directed scenarios plus a
// randomized run, compared against a behavioural model of the checker.
module tb_half_adder_checker;

   logic clk;
   logic rst_n;

   half_adder_checker_if #(.CNT_W(8)) if_a ();
   half_adder_checker_if #(.CNT_W(2)) if_b ();

   half_adder_checker #(.CNT_W(8)) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_chk(if_a));
   half_adder_checker #(.CNT_W(2)) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_chk(if_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Model of the 8-bit checker
   localparam int MAX_A = 255;
   int       m_vec;
   int       m_err;
   bit [3:0] m_cov;
   bit [3:0] m_first;
   bit       m_run;
   bit       m_done;
   bit       m_pass;
   bit       m_mm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_vec = 0; m_err = 0; m_cov = '0; m_first = '0;
      m_run = 0; m_done = 0; m_pass = 0; m_mm = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit v,
                             input bit b1, input bit b2, input bit s, input bit c);
      int tot;
      bit fail;
      m_mm = 0;
      if (st) begin
         m_run = 1; m_done = 0; m_pass = 0;
         m_vec = 0; m_err = 0; m_cov = '0; m_first = '0;
      end else if (m_run) begin
         if (v) begin
            tot  = int'(b1) + int'(b2);
            fail = (int'(s) != tot % 2) || (int'(c) != tot / 2);
            m_vec = (m_vec + 1 > MAX_A) ? MAX_A : m_vec + 1;
            m_cov[tot + int'(b1)] = 1'b1;   // index = 2*b1 + b2
            if (fail) begin
               if (m_err == 0) m_first = {b1, b2, s, c};
               m_err = (m_err + 1 > MAX_A) ? MAX_A : m_err + 1;
               m_mm  = 1;
            end
         end
         if (sp) begin
            m_run  = 0;
            m_done = 1;
            m_pass = (m_err == 0) && (m_cov == 4'b1111);
         end
      end
   endtask

   task automatic check_a(input string tag);
      chk({tag, ".busy"},  32'(if_a.o_busy),      32'(m_run));
      chk({tag, ".done"},  32'(if_a.o_done),      32'(m_done));
      chk({tag, ".pass"},  32'(if_a.o_pass),      32'(m_pass));
      chk({tag, ".mm"},    32'(if_a.o_mismatch),  32'(m_mm));
      chk({tag, ".vec"},   32'(if_a.o_vec_cnt),   32'(m_vec));
      chk({tag, ".err"},   32'(if_a.o_err_cnt),   32'(m_err));
      chk({tag, ".cov"},   32'(if_a.o_cov),       32'(m_cov));
      chk({tag, ".first"}, 32'(if_a.o_first_err), 32'(m_first));
   endtask

   // One clock of stimulus on DUT A, then compare against the model
   task automatic step(input string tag, input bit st, input bit sp, input bit v,
                       input bit b1, input bit b2, input bit s, input bit c);
      if_a.i_start = st; if_a.i_stop = sp; if_a.i_valid = v;
      if_a.i_bit1 = b1;  if_a.i_bit2 = b2; if_a.i_sum = s; if_a.i_carry = c;
      @(posedge clk);
      model_step(st, sp, v, b1, b2, s, c);
      #1;
      check_a(tag);
   endtask

   task automatic step_b(input bit st, input bit sp, input bit v,
                         input bit b1, input bit b2, input bit s, input bit c);
      if_b.i_start = st; if_b.i_stop = sp; if_b.i_valid = v;
      if_b.i_bit1 = b1;  if_b.i_bit2 = b2; if_b.i_sum = s; if_b.i_carry = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit st, sp, v, b1, b2, s, c;
      int tot;

      if_a.i_start = 0; if_a.i_stop = 0; if_a.i_valid = 0;
      if_a.i_bit1 = 0; if_a.i_bit2 = 0; if_a.i_sum = 0; if_a.i_carry = 0;
      if_b.i_start = 0; if_b.i_stop = 0; if_b.i_valid = 0;
      if_b.i_bit1 = 0; if_b.i_bit2 = 0; if_b.i_sum = 0; if_b.i_carry = 0;
      rst_n = 1'b0;
      model_reset();
      #7;
      check_a("reset");
      chk("reset.b_vec", 32'(if_b.o_vec_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four correct vectors then stop
      step("t1.start", 1, 0, 0, 0, 0, 0, 0);
      step("t1.v00",   0, 0, 1, 0, 0, 0, 0);
      step("t1.v01",   0, 0, 1, 0, 1, 1, 0);
      step("t1.v10",   0, 0, 1, 1, 0, 1, 0);
      step("t1.v11",   0, 0, 1, 1, 1, 0, 1);
      step("t1.stop",  0, 1, 0, 0, 0, 0, 0);
      chk("t1.vec4",  32'(if_a.o_vec_cnt), 32'd4);
      chk("t1.cov",   32'(if_a.o_cov),     32'hf);
      chk("t1.done",  32'(if_a.o_done),    32'd1);
      chk("t1.pass",  32'(if_a.o_pass),    32'd1);
      step("t1.hold", 0, 1, 1, 1, 1, 1, 1);   // stop/valid in DONE ignored

      // Faulty 11 vector
      step("t2.start", 1, 0, 0, 0, 0, 0, 0);
      step("t2.v00",   0, 0, 1, 0, 0, 0, 0);
      step("t2.v01",   0, 0, 1, 0, 1, 1, 0);
      step("t2.v10",   0, 0, 1, 1, 0, 1, 0);
      step("t2.v11bad",0, 0, 1, 1, 1, 1, 1);
      chk("t2.mm_hi",  32'(if_a.o_mismatch),  32'd1);
      chk("t2.first",  32'(if_a.o_first_err), 32'hf);
      step("t2.stop",  0, 1, 0, 0, 0, 0, 0);
      chk("t2.mm_lo",  32'(if_a.o_mismatch),  32'd0);
      chk("t2.err1",   32'(if_a.o_err_cnt),   32'd1);
      chk("t2.pass0",  32'(if_a.o_pass),      32'd0);

      // Coverage hole; stop coincident with the last sample
      step("t3.start", 1, 0, 0, 0, 0, 0, 0);
      step("t3.v00",   0, 0, 1, 0, 0, 0, 0);
      step("t3.v01st", 0, 1, 1, 0, 1, 1, 0);
      chk("t3.cov",    32'(if_a.o_cov),  32'h3);
      chk("t3.pass0",  32'(if_a.o_pass), 32'd0);

      // Start and stop together in RUN with a valid sample
      step("t5.start", 1, 0, 0, 0, 0, 0, 0);
      step("t5.v11",   0, 0, 1, 1, 1, 0, 1);
      step("t5.both",  1, 1, 1, 1, 1, 1, 1);
      chk("t5.vec0",   32'(if_a.o_vec_cnt), 32'd0);
      chk("t5.busy",   32'(if_a.o_busy),    32'd1);

      // Saturation on the 2-bit instance
      step_b(1, 0, 0, 0, 0, 0, 0);
      step_b(0, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step_b(0, 0, 1, 1, 1, 1, 1);
      chk("t4.vec_sat", 32'(if_b.o_vec_cnt),   32'd3);
      chk("t4.err_sat", 32'(if_b.o_err_cnt),   32'd3);
      chk("t4.first",   32'(if_b.o_first_err), 32'h4);
      chk("t4.mm",      32'(if_b.o_mismatch),  32'd1);
      step_b(0, 1, 0, 0, 0, 0, 0);
      chk("t4.done",    32'(if_b.o_done), 32'd1);
      chk("t4.pass0",   32'(if_b.o_pass), 32'd0);

      // Asynchronous reset mid-run after three samples
      step("t6.start", 1, 0, 0, 0, 0, 0, 0);
      step("t6.s1",    0, 0, 1, 0, 0, 0, 0);
      step("t6.s2",    0, 0, 1, 1, 1, 0, 0);
      step("t6.s3",    0, 0, 1, 1, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_a("t6.arst");
      @(negedge clk);
      rst_n = 1'b1;
      step("t6.idle",   0, 0, 1, 1, 1, 0, 0);   // valid in IDLE ignored
      step("t6.restart",1, 0, 0, 0, 0, 0, 0);
      step("t6.first",  0, 0, 1, 0, 1, 1, 0);
      chk("t6.vec1", 32'(if_a.o_vec_cnt), 32'd1);

      // Randomized traffic
      step("rnd.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         st  = ($urandom_range(0, 49) == 0);
         sp  = ($urandom_range(0, 24) == 0);
         v   = ($urandom_range(0, 3) != 0);
         b1  = 1'($urandom_range(0, 1));
         b2  = 1'($urandom_range(0, 1));
         tot = int'(b1) + int'(b2);
         if ($urandom_range(0, 5) != 0) begin
            s = 1'(tot % 2);
            c = 1'(tot / 2);
         end else begin
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
         end
         if (!m_run && $urandom_range(0, 3) == 0) st = 1;
         step("rnd", st, sp, v, b1, b2, s, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
